// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - byte-serial instruction fetch FSM (opcode + up to two operand bytes)
//
// Fetches one opcode byte, asks the external decoder for the instruction
// length, fetches 0..2 operand bytes and presents the instruction until acked.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   PC_in      [15:0]   program counter from the register file
//   inc_PC              pulse: advance PC by one (one per accepted byte)
//   mem_addr   [15:0]   read address (always PC_in)
//   mem_rd / mem_ready  read request / data valid handshake
//   mem_data   [7:0]    read data
//   instr_len  [1:0]    decoded length of the current opcode
//   opcode     [7:0]    registered opcode byte
//   operand    [15:0]   registered operand {hi, lo}
//   instr_valid         instruction complete and stable
//   instr_ack           consumer takes the instruction
//   flush               abort the fetch in progress (PC was reloaded)
//   fetch_fault         sticky memory-timeout flag

module instruction_fetch #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] PC_in,
  output logic        inc_PC,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ready,
  input  logic [7:0]  mem_data,
  input  logic [1:0]  instr_len,
  output logic [7:0]  opcode,
  output logic [15:0] operand,
  output logic        instr_valid,
  input  logic        instr_ack,
  input  logic        flush,
  output logic        fetch_fault
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_OP = 3'd1,
    DECODE   = 3'd2,
    FETCH_LO = 3'd3,
    FETCH_HI = 3'd4,
    HOLD     = 3'd5,
    FAULT    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] operand_q, operand_d;
  logic [1:0]  len_q, len_d;
  logic [15:0] stall_q, stall_d;
  logic        fault_q, fault_d;
  logic        valid_q;
  logic        fetching;

  assign mem_addr    = PC_in;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_valid = valid_q;
  assign fetch_fault = fault_q;

  assign fetching = (state_q == FETCH_OP) || (state_q == FETCH_LO) || (state_q == FETCH_HI);
  assign mem_rd   = fetching && !flush;
  assign inc_PC   = mem_rd && mem_ready;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    stall_d   = '0;
    fault_d   = fault_q;

    if (state_q == FAULT) begin
      // Terminal until reset; flush and instr_ack have no effect here.
      stall_d = stall_q;
    end else if (flush) begin
      // Opcode/operand are deliberately kept; the restarted fetch overwrites them.
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        IDLE:     state_d = FETCH_OP;
        FETCH_OP: if (mem_ready) begin
          opcode_d  = mem_data;
          operand_d = '0;
          state_d   = DECODE;
        end
        DECODE: begin
          len_d   = instr_len;
          state_d = instr_len[1] ? FETCH_LO : HOLD;
        end
        FETCH_LO: if (mem_ready) begin
          operand_d[7:0] = mem_data;
          state_d        = (len_q == 2'd3) ? FETCH_HI : HOLD;
        end
        FETCH_HI: if (mem_ready) begin
          operand_d[15:8] = mem_data;
          state_d         = HOLD;
        end
        HOLD:     if (instr_ack) state_d = FETCH_OP;
        default:  state_d = IDLE;
      endcase

      // Stalled read: count it, and give up once the budget is exhausted.
      if (mem_rd && !mem_ready) begin
        if (stall_q + 16'd1 == TIMEOUT_W) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
      stall_q   <= '0;
      fault_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      stall_q   <= stall_d;
      fault_q   <= fault_d;
      valid_q   <= (state_d == HOLD);
    end
  end

endmodule
